// File: rtl/wb_sram_arb2_pkg.sv
// Shared definitions for the two-master Wishbone SRAM arbiter.
// Holds the arbiter state encoding and one-hot grant codes so a future
// N-master variant can reuse the same names.
package wb_sram_arb2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN0   = 2'd1,
        ST_OWN1   = 2'd2,
        ST_SWITCH = 2'd3
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // One-hot grant presented while in a given state.
    function automatic logic [1:0] gnt_of(arb_state_e s);
        case (s)
            ST_OWN0: return GNT_M0;
            ST_OWN1: return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_sram_arb2.sv
// wb_sram_arb2 -- two-master round-robin Wishbone arbiter in front of the
// single 32-bit SRAM slave. Grants are whole-cycle; optional beat-count
// preemption bounds how long the waiting master stalls.
//
// Ports
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   m0_* / m1_*            Wishbone master ports (adr/dat/sel/we/cyc/stb/lock in,
//                          dat/ack/err out); m0 wins the first tie after reset
//   s_*                    Wishbone port toward the SRAM slave
//   gnt_o                  registered one-hot owner (01 = m0, 10 = m1, 00 = none)
module wb_sram_arb2
    import wb_sram_arb2_pkg::*;
#(
    parameter int adr_width = 32,
    parameter int max_beats = 16,
    parameter int cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic [adr_width-1:0] m0_adr_i,
    input  logic [31:0]          m0_dat_i,
    output logic [31:0]          m0_dat_o,
    input  logic [3:0]           m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_lock_i,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic [adr_width-1:0] m1_adr_i,
    input  logic [31:0]          m1_dat_i,
    output logic [31:0]          m1_dat_o,
    input  logic [3:0]           m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_lock_i,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic [adr_width-1:0] s_adr_o,
    output logic [31:0]          s_dat_o,
    input  logic [31:0]          s_dat_i,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,

    output logic [1:0]           gnt_o
);

    localparam bit PREEMPT_EN = (max_beats != 0);
    // Preempt on the ack that completes beat number max_beats: the counter
    // holds the acks already taken before this one.
    localparam logic [cnt_width-1:0] PREEMPT_AT =
        cnt_width'(PREEMPT_EN ? max_beats - 1 : 0);

    arb_state_e           state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 last_q, last_d;
    logic [cnt_width-1:0] beat_cnt_q, beat_cnt_d;

    logic own_is_m1;
    logic own_cyc;
    logic own_lock;
    logic oth_cyc;
    logic preempt;

    assign own_is_m1 = (state_q == ST_OWN1);
    assign own_cyc   = own_is_m1 ? m1_cyc_i  : m0_cyc_i;
    assign own_lock  = own_is_m1 ? m1_lock_i : m0_lock_i;
    assign oth_cyc   = own_is_m1 ? m0_cyc_i  : m1_cyc_i;

    assign preempt = PREEMPT_EN && (beat_cnt_q >= PREEMPT_AT) && s_ack_i
                     && oth_cyc && !own_lock;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                beat_cnt_d = '0;
                if (m0_cyc_i && m1_cyc_i) begin
                    // Tie goes to whichever master did not own the bus last.
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    state_d = ST_OWN0;
                end else if (m1_cyc_i) begin
                    state_d = ST_OWN1;
                end
            end

            ST_OWN0, ST_OWN1: begin
                // A voluntary release takes precedence over a simultaneous
                // preemption, and hands straight over without a dead cycle.
                if (!own_cyc) begin
                    last_d     = own_is_m1;
                    beat_cnt_d = '0;
                    if (oth_cyc) begin
                        state_d = own_is_m1 ? ST_OWN0 : ST_OWN1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (preempt) begin
                    last_d     = own_is_m1;
                    beat_cnt_d = '0;
                    state_d    = ST_SWITCH;
                end else if ((s_ack_i || s_err_i) && (beat_cnt_q != '1)) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end

            ST_SWITCH: begin
                // Hand to the master that was waiting; if it gave up in the
                // meantime fall back to IDLE, which re-grants the preempted one.
                beat_cnt_d = '0;
                if (last_q ? m0_cyc_i : m1_cyc_i) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        gnt_d = gnt_of(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_NONE;
            last_q     <= 1'b1;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign gnt_o = gnt_q;

    // Bus mux keyed on the registered grant, so reset silences the slave
    // side and the acks immediately.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;

        case (gnt_q)
            GNT_M0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
            end
            GNT_M1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_sram_arb2.sv
// Testbench for wb_sram_arb2: directed master traffic against a small SRAM
// model, with a scoreboard of expected beats per master and an expected grant
// sequence, both checked by a free-running monitor.
module tb_wb_sram_arb2;

    localparam int MAX_BEATS = 4;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] rdat;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    logic [1:0]  m_cyc, m_stb, m_we, m_lock;
    logic [31:0] m_adr  [2];
    logic [31:0] m_wdat [2];
    logic [3:0]  m_sel  [2];

    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]  gnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt0 = 0;
    int ack_cnt1 = 0;

    beat_t      q0 [$];
    beat_t      q1 [$];
    logic [1:0] gq [$];
    logic [1:0] gnt_prev = 2'b00;

    always #5 clk = ~clk;

    wb_sram_arb2 #(
        .adr_width(32),
        .max_beats(MAX_BEATS),
        .cnt_width(8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_adr_i (m_adr[0]),
        .m0_dat_i (m_wdat[0]),
        .m0_dat_o (m0_dat_o),
        .m0_sel_i (m_sel[0]),
        .m0_we_i  (m_we[0]),
        .m0_cyc_i (m_cyc[0]),
        .m0_stb_i (m_stb[0]),
        .m0_lock_i(m_lock[0]),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (m_adr[1]),
        .m1_dat_i (m_wdat[1]),
        .m1_dat_o (m1_dat_o),
        .m1_sel_i (m_sel[1]),
        .m1_we_i  (m_we[1]),
        .m1_cyc_i (m_cyc[1]),
        .m1_stb_i (m_stb[1]),
        .m1_lock_i(m_lock[1]),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .gnt_o    (gnt_o)
    );

    // Initial SRAM contents; word 4 (0x...10) holds 0xDEADBEEF.
    function automatic logic [31:0] preload(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    // SRAM model: registered ack, one beat every other cycle.
    logic [31:0] mem [16];
    logic        sl_ack;
    logic [31:0] sl_rdat;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sl_ack <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= preload(i);
        end else begin
            sl_ack <= s_cyc_o && s_stb_o && !sl_ack;
            if (s_cyc_o && s_stb_o && !sl_ack) begin
                sl_rdat <= mem[s_adr_o[5:2]];
                if (s_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (s_sel_o[b]) mem[s_adr_o[5:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
                end
            end
        end
    end

    assign s_ack_i = sl_ack;
    assign s_dat_i = sl_rdat;
    assign s_err_i = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void report_fail(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endfunction

    // Monitor: grant sequence, quiet bus while ungranted, beat routing/data.
    initial begin : monitor
        beat_t b;
        int    id;
        bit    has;
        forever begin
            @(negedge clk);
            if (gnt_o !== gnt_prev) begin
                if (gq.size() > 0) check("gnt_seq", 64'(gnt_o), 64'(gq.pop_front()));
                else report_fail("gnt_unexpected", 64'(gnt_o));
                gnt_prev = gnt_o;
            end
            if (reset_n && gnt_o == 2'b00 && m_cyc != 2'b00)
                check("nogrant_quiet", 64'({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 64'd0);
            if (s_ack_i || m0_ack_o || m1_ack_o) begin
                if (gnt_o == 2'b01 || gnt_o == 2'b10) begin
                    id = gnt_o[1] ? 1 : 0;
                    check("ack_route", 64'({m1_ack_o, m0_ack_o}), 64'(s_ack_i ? gnt_o : 2'b00));
                    if (s_ack_i) begin
                        has = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        if (!has) begin
                            report_fail($sformatf("m%0d_beat_unexpected", id), 64'(s_adr_o));
                        end else begin
                            if (id == 0) begin b = q0.pop_front(); ack_cnt0++; end
                            else begin b = q1.pop_front(); ack_cnt1++; end
                            check($sformatf("m%0d_adr", id), 64'(s_adr_o), 64'(b.adr));
                            check($sformatf("m%0d_we", id), 64'(s_we_o), 64'(b.we));
                            check($sformatf("m%0d_sel", id), 64'(s_sel_o), 64'(b.sel));
                            if (b.we) check($sformatf("m%0d_wdat", id), 64'(s_dat_o), 64'(b.wdat));
                            else check($sformatf("m%0d_rdat", id), 64'(id ? m1_dat_o : m0_dat_o), 64'(b.rdat));
                        end
                    end
                end else begin
                    check("ack_blocked", 64'({m1_ack_o, m0_ack_o}), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: time limit reached, got %0d tests", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ack(input int id);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = (id == 0) ? m0_ack_o : m1_ack_o;
        end
        if (!got) report_fail($sformatf("m%0d_ack_timeout", id), 64'(gnt_o));
        @(posedge clk);
        #1;
    endtask

    task automatic master_burst(input int id, input int n, input int base_idx,
                                input logic we, input logic lock);
        beat_t b;
        int    idx;
        for (int i = 0; i < n; i++) begin
            idx    = (base_idx + i) % 16;
            b.adr  = 32'h4000_0000 + 32'(idx) * 32'd4;
            b.we   = we;
            b.wdat = 32'hC0DE_0000 + 32'(id * 256 + i);
            b.sel  = we ? ((i % 2) ? 4'b1100 : 4'b0011) : 4'hF;
            b.rdat = we ? 32'h0 : preload(idx);
            if (id == 0) q0.push_back(b); else q1.push_back(b);
            m_adr[id]  = b.adr;
            m_wdat[id] = b.wdat;
            m_sel[id]  = b.sel;
            m_we[id]   = we;
            m_lock[id] = lock;
            m_cyc[id]  = 1'b1;
            m_stb[id]  = 1'b1;
            wait_ack(id);
        end
        m_cyc[id]  = 1'b0;
        m_stb[id]  = 1'b0;
        m_we[id]   = 1'b0;
        m_lock[id] = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00; m_lock = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = 32'h0; m_wdat[i] = 32'h0; m_sel[i] = 4'h0;
        end
        #1;
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_outs", 64'({s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic end_test(input string name);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_m0_beats_left"}, 64'(q0.size()), 64'd0);
        check({name, "_m1_beats_left"}, 64'(q1.size()), 64'd0);
        check({name, "_gnt_left"}, 64'(gq.size()), 64'd0);
        q0.delete(); q1.delete(); gq.delete();
    endtask

    initial begin : stimulus
        int  base;
        bit  found;
        beat_t b;

        // 1: single m0 read, grant one cycle after cyc
        do_reset();
        gq.push_back(2'b01); gq.push_back(2'b00);
        b.adr = 32'h4000_0010; b.we = 1'b0; b.wdat = 32'h0; b.sel = 4'hF; b.rdat = 32'hDEAD_BEEF;
        q0.push_back(b);
        m_adr[0] = 32'h4000_0010; m_sel[0] = 4'hF; m_we[0] = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        @(negedge clk);
        check("t1_gnt_idle_cycle", 64'(gnt_o), 64'd0);
        @(negedge clk);
        check("t1_gnt", 64'(gnt_o), 64'h1);
        check("t1_s_cyc", 64'({s_cyc_o, s_stb_o}), 64'h3);
        check("t1_s_adr", 64'(s_adr_o), 64'h4000_0010);
        wait_ack(0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        end_test("t1");

        // 2: simultaneous request, m0 first, direct handover to m1
        do_reset();
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b00);
        fork
            master_burst(0, 1, 1, 1'b0, 1'b0);
            master_burst(1, 1, 2, 1'b0, 1'b0);
        join
        end_test("t2");

        // 3: alternating single beats, 8 per master
        do_reset();
        for (int i = 0; i < 8; i++) begin gq.push_back(2'b01); gq.push_back(2'b10); end
        gq.push_back(2'b00);
        base = ack_cnt0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    master_burst(0, 1, 8 + i, 1'b1, 1'b0);
                    @(posedge clk); #1;
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    master_burst(1, 1, i, 1'b0, 1'b0);
                    @(posedge clk); #1;
                end
            end
        join
        check("t3_m0_beats", 64'(ack_cnt0 - base), 64'd8);
        end_test("t3");

        // 4: unlocked 10-beat m0 burst preempted after 4 beats
        do_reset();
        gq.push_back(2'b01); gq.push_back(2'b00); gq.push_back(2'b10);
        gq.push_back(2'b01); gq.push_back(2'b00);
        base = ack_cnt0;
        fork
            master_burst(0, 10, 6, 1'b1, 1'b0);
            begin repeat (2) @(posedge clk); #1; master_burst(1, 2, 0, 1'b0, 1'b0); end
            begin
                found = 1'b0;
                for (int c = 0; c < 100 && !found; c++) begin @(negedge clk); found = (gnt_o == 2'b01); end
                found = 1'b0;
                for (int c = 0; c < 100 && !found; c++) begin @(negedge clk); found = (gnt_o == 2'b00); end
                check("t4_switch_seen", 64'(found), 64'd1);
                check("t4_beats_before_switch", 64'(ack_cnt0 - base), 64'd4);
                check("t4_switch_quiet", 64'({s_cyc_o, s_stb_o, m_cyc[0], m_stb[0]}), 64'h3);
                @(negedge clk);
                check("t4_switch_one_cycle", 64'(gnt_o), 64'h2);
            end
        join
        check("t4_m0_beats", 64'(ack_cnt0 - base), 64'd10);
        end_test("t4");

        // 5: same burst locked, never preempted
        do_reset();
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b00);
        base = ack_cnt0;
        fork
            master_burst(0, 10, 6, 1'b1, 1'b1);
            begin repeat (2) @(posedge clk); #1; master_burst(1, 2, 0, 1'b0, 1'b0); end
            begin
                found = 1'b0;
                for (int c = 0; c < 100 && !found; c++) begin @(negedge clk); found = (gnt_o == 2'b10); end
                check("t5_m1_granted", 64'(found), 64'd1);
                check("t5_m0_beats_before_m1", 64'(ack_cnt0 - base), 64'd10);
            end
        join
        end_test("t5");

        // 6: asynchronous reset mid-beat, then m0 wins the tie again
        do_reset();
        gq.push_back(2'b01); gq.push_back(2'b00);
        m_adr[0] = 32'h4000_0004; m_sel[0] = 4'hF; m_we[0] = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_pre_gnt", 64'(gnt_o), 64'h1);
        check("t6_pre_stb", 64'({s_cyc_o, s_stb_o}), 64'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_gnt", 64'(gnt_o), 64'd0);
        check("t6_async_outs", 64'({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}), 64'd0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b00);
        fork
            master_burst(0, 1, 3, 1'b0, 1'b0);
            master_burst(1, 1, 5, 1'b0, 1'b0);
        join
        end_test("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
